// File: rtl/atari_qspi_pkg.sv
// atari_qspi_pkg: shared state encoding and frame lengths for the QSPI ROM fetcher
package atari_qspi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;
  localparam int CMD_NIBBLES = 2;
  localparam int ADDR_NIBBLES = 6;
  localparam int DATA_NIBBLES = 2;
endpackage

// File: rtl/qspi_rr_arb2.sv
// qspi_rr_arb2: two-way round-robin arbiter; the port not served last wins a tie
module qspi_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt,
  output logic gnt_id
);
  logic last;
  assign gnt = en && (req0 || req1);
  assign gnt_id = (req0 && req1) ? !last : req1;
  // last-served pointer, starting as if port 1 was served so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (gnt) last <= gnt_id;
endmodule

// File: rtl/qspi_rom_fetch_ctrl.sv
// qspi_rom_fetch_ctrl: arbitrated QSPI ROM byte fetcher; define QSPI_LAST_BYTE_CACHE_EN for a one-entry last-byte cache
module qspi_rom_fetch_ctrl
  import atari_qspi_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter logic [23:0] ROM_BASE = 24'h000000,
  parameter logic [7:0] CMD_BYTE = 8'h0B,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              qspi_cs_n,
  output logic              qspi_sck,
  output logic [3:0]        qspi_dout,
  output logic [3:0]        qspi_oe,
  input  logic [3:0]        qspi_din
);
  state_t state, state_n;
  logic ph, port, active, last_nib, step, gnt, gnt_id, hit, hit_ack;
  logic [3:0] cnt, hi_q;
  logic [23:0] addr_q, addr_sh;
  logic [7:0] hit_data;
  logic [ADDR_W-1:0] gnt_addr;
  assign gnt_addr = gnt_id ? addr1 : addr0;
  qspi_rr_arb2 u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req0(req0),
    .req1(req1),
    .en(state == S_IDLE && !hit_ack),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );
  // frame sequencing and pin decode from the state, SCK phase and nibble counter
  always_comb begin
    active = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
    last_nib = state == S_CMD ? cnt == 4'(CMD_NIBBLES - 1)
             : state == S_ADDR ? cnt == 4'(ADDR_NIBBLES - 1)
             : state == S_DUMMY ? cnt == 4'(DUMMY_CYCLES - 1)
             : cnt == 4'(DATA_NIBBLES - 1);
    step = ph && last_nib;
    state_n = state == S_IDLE ? ((gnt && !hit) ? S_CMD : S_IDLE)
            : state == S_DONE ? S_IDLE
            : !step ? state
            : state == S_CMD ? S_ADDR
            : state == S_ADDR ? ((DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY)
            : state == S_DUMMY ? S_DATA
            : S_DONE;
    addr_sh = addr_q << {cnt, 2'b00};
    qspi_cs_n = !active;
    qspi_sck = active && ph;
    qspi_oe = (state == S_CMD || state == S_ADDR) ? 4'hF : 4'h0;
    qspi_dout = state == S_CMD ? (cnt[0] ? CMD_BYTE[3:0] : CMD_BYTE[7:4])
              : state == S_ADDR ? addr_sh[23:20]
              : 4'h0;
    busy = state != S_IDLE;
    ack0 = (state == S_DONE || hit_ack) && !port;
    ack1 = (state == S_DONE || hit_ack) && port;
  end
  // transaction sequencer: state, SCK phase, nibble count, grant latch and read byte assembly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ph <= 1'b0;
      cnt <= 4'd0;
      port <= 1'b0;
      addr_q <= 24'h0;
      hi_q <= 4'h0;
      rdata <= 8'h00;
    end else begin
      state <= state_n;
      ph <= active && !ph;
      cnt <= (!active || step) ? 4'd0 : cnt + {3'd0, ph};
      if (gnt) begin
        port <= gnt_id;
        addr_q <= ROM_BASE + 24'(gnt_addr);
      end
      if (gnt && hit) rdata <= hit_data;
      if (state == S_DATA && ph) begin
        if (cnt == 4'd0) hi_q <= qspi_din;
        else rdata <= {hi_q, qspi_din};
      end
    end
`ifdef QSPI_LAST_BYTE_CACHE_EN
  logic c_vld;
  logic [ADDR_W-1:0] c_addr, a_q;
  logic [7:0] c_data;
  assign hit = c_vld && c_addr == gnt_addr;
  assign hit_data = c_data;
  // last-byte cache: one-cycle ack on a hit, refill from each completed fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_addr <= '0;
      a_q <= '0;
      c_data <= 8'h00;
      hit_ack <= 1'b0;
    end else begin
      hit_ack <= gnt && hit;
      if (gnt) a_q <= gnt_addr;
      if (state == S_DONE) begin
        c_vld <= 1'b1;
        c_addr <= a_q;
        c_data <= rdata;
      end
    end
`else
  assign hit = 1'b0;
  assign hit_ack = 1'b0;
  assign hit_data = 8'h00;
`endif
endmodule

// File: tb/tb_qspi_rom_fetch_ctrl.sv
// tb_qspi_rom_fetch_ctrl: two configurations against a QSPI ROM bus model and a requester-level timing model
module tb_qspi_rom_fetch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  function automatic logic [7:0] rom(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h78;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask
  for (genvar k = 0; k < 2; k++) begin : g
    localparam logic [23:0] BASE = (k == 0) ? 24'h000000 : 24'hFFFFFF;
    localparam int D = (k == 0) ? 2 : 0;
    localparam int L = 2 * (10 + D) + 1;
    logic rst_n, req0, req1, ack0, ack1, busy, cs_n, sck;
    logic [11:0] addr0, addr1;
    logic [7:0] rdata;
    logic [3:0] dout, oe, din;
    bit done = 1'b0;
    qspi_rom_fetch_ctrl #(.ROM_BASE(BASE), .DUMMY_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .qspi_cs_n(cs_n), .qspi_sck(sck), .qspi_dout(dout), .qspi_oe(oe), .qspi_din(din)
    );
    int cnt, n;
    bit last, mport, mh, cvld, prev;
    logic [11:0] maddr, caddr;
    logic [7:0] exp_rd, b;
    logic [31:0] cap;
    // ROM: collect command/address nibbles on SCK rise, answer with the addressed byte after the dummy cycles
    always @(posedge clk) begin
      #1;
      if (cs_n) begin
        n = 0;
        prev = 1'b0;
      end else begin
        if (sck && !prev) begin
          if (n < 8) cap = {cap[27:0], dout};
          if (n == 7) begin
            chk("cmd", k, 32'(cap[31:24]), 32'h0B);
            chk("taddr", k, 32'(cap[23:0]), 32'(24'(BASE + 24'(maddr))));
          end
          b = rom(cap[23:0]);
          if (n == 8 + D) din = b[7:4];
          if (n == 9 + D) din = b[3:0];
          n++;
        end
        prev = sck;
      end
    end
    // requester-level model: a granted fetch acks L cycles later (1 on a cache hit), compared every cycle
    always @(negedge clk) begin
      if (!rst_n) begin
        cnt = 0; last = 1'b1; mh = 1'b0; cvld = 1'b0; exp_rd = 8'h00;
        chk("rst_outs", k, 32'({ack0, ack1, busy, cs_n, sck, oe, dout, rdata}), 32'h0002_0000);
      end else begin
        if (cnt == L || mh) exp_rd = rom(24'(BASE + 24'(maddr)));
        chk("ack0", k, 32'(ack0), 32'((cnt == L || mh) && !mport));
        chk("ack1", k, 32'(ack1), 32'((cnt == L || mh) && mport));
        chk("busy", k, 32'(busy), 32'(cnt != 0));
        chk("cs_n", k, 32'(cs_n), 32'(!(cnt >= 1 && cnt < L)));
        chk("oe", k, 32'(oe), (cnt >= 1 && cnt <= 16) ? 32'hF : 32'h0);
        chk("rdata", k, 32'(rdata), 32'(exp_rd));
        if (cnt == L) begin
          cnt = 0;
`ifdef QSPI_LAST_BYTE_CACHE_EN
          cvld = 1'b1;
          caddr = maddr;
`endif
        end else if (cnt != 0) cnt++;
        else if (mh) mh = 1'b0;
        else if (req0 || req1) begin
          mport = (req0 && req1) ? !last : req1;
          last = mport;
          maddr = mport ? addr1 : addr0;
`ifdef QSPI_LAST_BYTE_CACHE_EN
          if (cvld && caddr == maddr) mh = 1'b1;
          else cnt = 1;
`else
          cnt = 1;
`endif
        end
      end
    end
    task automatic xfer(input bit p, input logic [11:0] a, output int lat);
      if (p) begin req1 = 1'b1; addr1 = a; end
      else begin req0 = 1'b1; addr0 = a; end
      lat = 0;
      forever begin
        @(negedge clk);
        if (p ? ack1 : ack0) break;
        if (lat == 200) begin
          chk("ack_timeout", k, 32'(lat), 32'(L));
          break;
        end
        @(posedge clk);
        #1;
        lat++;
      end
    endtask
    task automatic wait_ack(output int p);
      p = -1;
      for (int i = 0; i < 200 && p < 0; i++) begin
        @(negedge clk);
        if (ack0 || ack1) p = ack1 ? 1 : 0;
      end
    endtask
    task automatic rand_port(input bit p);
      int lat;
      logic [11:0] a = 12'h0;
      for (int i = 0; i < 30; i++) begin
        int gap;
        @(posedge clk);
        #1;
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          if (p) req1 = 1'b0; else req0 = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
        if ($urandom_range(0, 2) != 0) a = 12'($urandom);
        xfer(p, a, lat);
      end
      @(posedge clk);
      #1;
      if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask
    initial begin
      int lat, p;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = 12'h0; addr1 = 12'h0; din = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer(1'b0, (k == 0) ? 12'h123 : 12'h002, lat);
      chk("lat_first", k, 32'(lat), (k == 0) ? 32'd25 : 32'd21);
      chk("rdata_first", k, 32'(rdata), (k == 0) ? 32'h5A : 32'h79);
      chk("frame_first", k, cap, (k == 0) ? 32'h0B00_0123 : 32'h0B00_0001);
      chk("cs_n_done", k, 32'(cs_n), 32'd1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) begin
        @(posedge clk);
        #1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 12'h0A0; addr1 = 12'h0B1;
        wait_ack(p);
        chk("order_first", k, 32'(p), 32'd0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_ack(p);
        chk("order_second", k, 32'(p), 32'd1);
        @(posedge clk);
        #1;
        req1 = 1'b0;
      end
      @(posedge clk);
      #1;
      req0 = 1'b1; addr0 = 12'h456;
      repeat (8) @(posedge clk);
      #2;
      chk("pre_rst_oe", k, 32'(oe), 32'hF);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_cs_n", k, 32'(cs_n), 32'd1);
      chk("rst_sck", k, 32'(sck), 32'd0);
      chk("rst_oe", k, 32'(oe), 32'd0);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        chk("no_ack_after_rst", k, 32'(ack0 || ack1), 32'd0);
      end
      @(posedge clk);
      #1;
      xfer(1'b0, 12'h456, lat);
      chk("lat_after_rst", k, 32'(lat), 32'(L));
      chk("rdata_after_rst", k, 32'(rdata), 32'(rom(24'(BASE + 24'h456))));
      @(posedge clk);
      #1;
      req0 = 1'b0;
`ifdef QSPI_LAST_BYTE_CACHE_EN
      @(posedge clk);
      #1;
      xfer(1'b0, 12'h0FF, lat);
      chk("miss_lat", k, 32'(lat), 32'(L));
      @(posedge clk);
      #1;
      req0 = 1'b0;
      @(posedge clk);
      #1;
      xfer(1'b0, 12'h0FF, lat);
      chk("hit_lat", k, 32'(lat), 32'd1);
      chk("hit_data", k, 32'(rdata), 32'(rom(24'(BASE + 24'h0FF))));
      chk("hit_quiet", k, 32'({busy, cs_n}), 32'b01);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      @(posedge clk);
      #1;
      xfer(1'b0, 12'h100, lat);
      chk("new_addr_lat", k, 32'(lat), 32'(L));
      @(posedge clk);
      #1;
      req0 = 1'b0;
`endif
      fork
        rand_port(1'b0);
        rand_port(1'b1);
      join
      repeat (30) @(posedge clk);
      done = 1'b1;
    end
  end
  initial begin
    fork
      wait (g[0].done && g[1].done);
      begin
        #1000000;
        chk("global_timeout", 0, 32'(g[0].done && g[1].done), 32'd1);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
